// File: rtl/avalon_mm_regfile_slave.sv
// Avalon-MM register bank responder with a programmable number of wait states.
// One transfer at a time: request latched in IDLE, acknowledged for exactly one cycle.
module avalon_mm_regfile_slave #(
    parameter int unsigned AW          = 8,
    parameter int unsigned DW          = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   address,
    input  logic            read,
    input  logic            write,
    input  logic [DW-1:0]   writedata,
    input  logic [DW/8-1:0] byteenable,
    output logic            waitrequest,
    output logic [DW-1:0]   readdata
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [BW-1:0]   lat_be;
    logic            lat_wr;
    logic [DW-1:0]   regs [DEPTH];

    logic [AW-1:0]   op_addr_c;
    logic [DW-1:0]   op_wdata_c;
    logic [BW-1:0]   op_be_c;
    logic            op_wr_c;
    logic            op_hit_c;
    logic [IW-1:0]   op_idx_c;
    logic            req_c;
    logic            go_ack_c;

    // With zero wait states the commit happens on the latching edge, so the
    // operation comes straight from the bus in IDLE and from the latches otherwise.
    always_comb begin
        op_addr_c  = lat_addr;
        op_wdata_c = lat_wdata;
        op_be_c    = lat_be;
        op_wr_c    = lat_wr;
        if (state == S_IDLE) begin
            op_addr_c  = address;
            op_wdata_c = writedata;
            op_be_c    = byteenable;
            op_wr_c    = write;
        end
        op_hit_c = ({1'b0, op_addr_c} < (AW+1)'(DEPTH));
        op_idx_c = op_addr_c[IW-1:0];
        req_c    = read | write;
        go_ack_c = 1'b0;
        if (req_c) begin
            if (state == S_IDLE)
                go_ack_c = (WAIT_CYCLES == 0);
            else if (state == S_WAIT)
                go_ack_c = (cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_be      <= '0;
            lat_wr      <= 1'b0;
            waitrequest <= 1'b1;
            readdata    <= '0;
            for (int i = 0; i < int'(DEPTH); i++)
                regs[i] <= '0;
        end else begin
            waitrequest <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (req_c) begin
                        lat_addr  <= address;
                        lat_wdata <= writedata;
                        lat_be    <= byteenable;
                        lat_wr    <= write;
                        if (WAIT_CYCLES == 0) begin
                            state       <= S_ACK;
                            waitrequest <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                            cnt   <= CW'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!req_c) begin
                        state <= S_IDLE;
                    end else if (cnt == '0) begin
                        state       <= S_ACK;
                        waitrequest <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_ACK: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Commit on the edge that enters ACK; out-of-range writes are dropped.
            if (go_ack_c) begin
                if (op_wr_c) begin
                    if (op_hit_c) begin
                        for (int b = 0; b < int'(BW); b++) begin
                            if (op_be_c[b])
                                regs[op_idx_c][b*8 +: 8] <= op_wdata_c[b*8 +: 8];
                        end
                    end
                end else begin
                    readdata <= op_hit_c ? regs[op_idx_c] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_avalon_mm_regfile_slave.sv
// Bench for avalon_mm_regfile_slave: three instances (1, 3 and 0 wait states),
// a scoreboard of expected acknowledges and a monitor that checks them.
module tb_avalon_mm_regfile_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [3:0]  byteenable = '0;
    logic        rd [3];
    logic        wr [3];
    logic        wreq [3];
    logic [31:0] rdata [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          dut;
        bit          chk;
        logic [31:0] data;
        int          exp_cyc;
    } item_t;

    item_t sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    avalon_mm_regfile_slave #(.AW(8), .DW(32), .DEPTH(16), .WAIT_CYCLES(1)) dut_w1 (
        .clk(clk), .reset_n(reset_n), .address(address), .read(rd[0]), .write(wr[0]),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(wreq[0]), .readdata(rdata[0]));

    avalon_mm_regfile_slave #(.AW(8), .DW(32), .DEPTH(16), .WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .reset_n(reset_n), .address(address), .read(rd[1]), .write(wr[1]),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(wreq[1]), .readdata(rdata[1]));

    avalon_mm_regfile_slave #(.AW(8), .DW(32), .DEPTH(16), .WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .reset_n(reset_n), .address(address), .read(rd[2]), .write(wr[2]),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(wreq[2]), .readdata(rdata[2]));

    function automatic int wait_of(input int d);
        case (d)
            0: return 1;
            1: return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every acknowledge must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < 3; d++) begin
                if (wreq[d] === 1'b0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ack", 32'(d), 32'hFFFF_FFFF);
                    end else begin
                        item_t it;
                        it = sb.pop_front();
                        check("ack_dut", 32'(d), 32'(it.dut));
                        check("ack_cycle", 32'(cyc), 32'(it.exp_cyc));
                        if (it.chk)
                            check("readdata", rdata[d], it.data);
                    end
                end
            end
        end
    end

    // Full transfer on instance d; returns after the completion edge.
    task automatic xfer(input int d, input bit w, input bit r, input logic [7:0] a,
                        input logic [31:0] dat, input logic [3:0] be,
                        input bit chk, input logic [31:0] exp);
        item_t it;
        int    n;
        @(negedge clk);
        it.dut = d; it.chk = chk; it.data = exp; it.exp_cyc = cyc + 1 + wait_of(d);
        sb.push_back(it);
        address = a; writedata = dat; byteenable = be;
        wr[d] = w; rd[d] = r;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wreq[d] !== 1'b0 && n < 40);
        if (wreq[d] !== 1'b0) begin
            check("ack_timeout", 32'(n), 32'(wait_of(d) + 1));
            void'(sb.pop_back());
        end else begin
            @(posedge clk);
            #1;
        end
        wr[d] = 1'b0; rd[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("reset_waitrequest", 32'(wreq[d]), 32'd1);
            check("reset_readdata", rdata[d], 32'd0);
        end
        reset_n = 1'b1;
        @(negedge clk);

        // Single wait state: basic write/read, reset contents, partial byte enables.
        xfer(0, 1, 0, 8'd10, 32'd20, 4'hF, 0, '0);
        xfer(0, 0, 1, 8'd10, '0, 4'h0, 1, 32'd20);
        xfer(0, 0, 1, 8'd5, '0, 4'h0, 1, 32'd0);
        xfer(0, 1, 0, 8'd15, 32'd25, 4'hF, 0, '0);
        xfer(0, 0, 1, 8'd15, '0, 4'h0, 1, 32'd25);
        xfer(0, 0, 1, 8'd8, '0, 4'h0, 1, 32'd0);
        xfer(0, 1, 0, 8'd3, 32'h1122_3344, 4'hF, 0, '0);
        xfer(0, 1, 0, 8'd3, 32'hAABB_CCDD, 4'b0101, 0, '0);
        xfer(0, 0, 1, 8'd3, '0, 4'h0, 1, 32'h11BB_33DD);

        // Out of range: acknowledged, dropped, no aliasing onto reg 4.
        xfer(0, 1, 0, 8'd20, 32'd7, 4'hF, 0, '0);
        xfer(0, 0, 1, 8'd20, '0, 4'h0, 1, 32'd0);
        xfer(0, 0, 1, 8'd4, '0, 4'h0, 1, 32'd0);

        // Zero wait states: read+write together is a write.
        xfer(2, 1, 1, 8'd2, 32'd9, 4'hF, 0, '0);
        xfer(2, 0, 1, 8'd2, '0, 4'h0, 1, 32'd9);

        // Three wait states: normal transfer, then an aborted write.
        xfer(1, 1, 0, 8'd1, 32'h55, 4'hF, 0, '0);
        xfer(1, 0, 1, 8'd1, '0, 4'h0, 1, 32'h55);
        @(negedge clk);
        address = 8'd6; writedata = 32'h77; byteenable = 4'hF; wr[1] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_waitrequest", 32'(wreq[1]), 32'd1);
        end
        wr[1] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("abort_idle_waitrequest", 32'(wreq[1]), 32'd1);
        end
        xfer(1, 0, 1, 8'd6, '0, 4'h0, 1, 32'd0);
        xfer(1, 0, 1, 8'd1, '0, 4'h0, 1, 32'h55);

        // Reset pulse while a read is waiting.
        @(negedge clk);
        address = 8'd1; rd[1] = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midreset_waitrequest", 32'(wreq[1]), 32'd1);
        check("midreset_readdata", rdata[1], 32'd0);
        rd[1] = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("postreset_waitrequest", 32'(wreq[1]), 32'd1);
        xfer(1, 0, 1, 8'd1, '0, 4'h0, 1, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule
